// File: rtl/video_if.sv
// Raster output bundle from the timing generator to the panel/encoder.
// The master drives every signal; the slave only observes.
interface video_if;
  logic        clk;
  logic        hs;
  logic        vs;
  logic        blank;
  logic [23:0] rgb;

  modport master (output clk, hs, vs, blank, rgb);
  modport slave  (input  clk, hs, vs, blank, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable VGA/LCD raster generator. It offers grid, colour-bar, solid and
// streamed-FIFO pixel sources, and starts and stops only on frame boundaries.
module vga_timing_gen #(
  parameter int          HDISP         = 800,
  parameter int          VDISP         = 480,
  parameter int          HFP           = 40,
  parameter int          HPULSE        = 48,
  parameter int          HBP           = 40,
  parameter int          VFP           = 13,
  parameter int          VPULSE        = 3,
  parameter int          VBP           = 29,
  parameter bit          HS_POL        = 1'b0,
  parameter bit          VS_POL        = 1'b0,
  parameter int          GRID_STEP     = 16,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  input  logic [23:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  input  logic        underflow_clr,
  output logic        underflow,
  output logic        frame_start,
  output logic        state_dbg,
  video_if.master     video_ifm
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int BARW   = HDISP / 8;
  localparam int BW     = (BARW > 1) ? $clog2(BARW) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  hcnt, hcnt_d;
  logic [VW-1:0]  vcnt, vcnt_d;
  logic [1:0]     mode_q;
  logic [23:0]    solid_q;
  logic           latch_cfg;
  logic           uf_set, uf_clr;

  logic           hs_q, vs_q, blank_q, fs_q;
  logic [23:0]    rgb_q;
  logic           hs_d, vs_d, blank_d, fs_d;
  logic [23:0]    rgb_d;

  logic           last_h, last_v, at_origin;
  logic           hs_act, vs_act, h_active, active;
  logic [HW-1:0]  x;
  logic [VW-1:0]  y;

  logic [2:0]     bar_idx;
  logic [BW-1:0]  bar_pos;
  logic [23:0]    grid_rgb, bar_rgb;

  assign last_h    = (hcnt == HW'(HTOTAL - 1));
  assign last_v    = (vcnt == VW'(VTOTAL - 1));
  assign at_origin = (hcnt == '0) && (vcnt == '0);
  assign hs_act    = (hcnt >= HW'(HFP)) && (hcnt < HW'(HFP + HPULSE));
  assign vs_act    = (vcnt >= VW'(VFP)) && (vcnt < VW'(VFP + VPULSE));
  assign h_active  = (hcnt >= HW'(HSTART));
  assign active    = h_active && (vcnt >= VW'(VSTART));
  assign x         = hcnt - HW'(HSTART);
  assign y         = vcnt - VW'(VSTART);

  // Bar index tracks the current x; it is re-armed on the pixel before x = 0
  // so the first active pixel already sees bar 0, and saturates on the last bar.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      bar_idx <= '0;
      bar_pos <= '0;
    end else if (hcnt == HW'(HSTART - 1)) begin
      bar_idx <= '0;
      bar_pos <= '0;
    end else if (h_active) begin
      if (bar_pos == BW'(BARW - 1)) begin
        bar_pos <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + BW'(1);
      end
    end
  end

  always_comb begin
    grid_rgb = 24'h000000;
    if (((x & HW'(GRID_STEP - 1)) == '0) || ((y & VW'(GRID_STEP - 1)) == '0))
      grid_rgb = 24'hFFFFFF;
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // FIFO handshake: show-ahead source. fifo_data is the head word whenever
  // fifo_empty is low; fifo_rd high in a cycle pops that head at the next edge,
  // and is only raised while fifo_empty is low.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt;
    vcnt_d    = vcnt;
    latch_cfg = 1'b0;
    fifo_rd   = 1'b0;
    uf_set    = 1'b0;
    uf_clr    = 1'b0;
    hs_d      = ~HS_POL;
    vs_d      = ~VS_POL;
    blank_d   = 1'b0;
    rgb_d     = 24'h000000;
    fs_d      = 1'b0;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (enable) begin
          state_d   = RUN;
          latch_cfg = 1'b1;
        end
      end
      RUN: begin
        latch_cfg = at_origin;
        uf_clr    = underflow_clr;
        if (last_h) begin
          hcnt_d = '0;
          vcnt_d = last_v ? '0 : vcnt + VW'(1);
          if (last_v && !enable) state_d = IDLE;
        end else begin
          hcnt_d = hcnt + HW'(1);
        end
        hs_d    = hs_act ? HS_POL : ~HS_POL;
        vs_d    = vs_act ? VS_POL : ~VS_POL;
        blank_d = active;
        fs_d    = at_origin;
        if (active) begin
          case (mode_q)
            2'd0: rgb_d = grid_rgb;
            2'd1: rgb_d = bar_rgb;
            2'd2: begin
              if (fifo_empty) begin
                rgb_d  = UNDERFLOW_RGB;
                uf_set = 1'b1;
              end else begin
                rgb_d   = fifo_data;
                fifo_rd = 1'b1;
              end
            end
            default: rgb_d = solid_q;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hcnt      <= '0;
      vcnt      <= '0;
      mode_q    <= '0;
      solid_q   <= '0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_q   <= 1'b0;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      hcnt    <= hcnt_d;
      vcnt    <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
      if (latch_cfg) begin
        mode_q  <= mode;
        solid_q <= solid_rgb;
      end
      // A new underflow in the same cycle as a clear keeps the flag set.
      if (uf_set)      underflow <= 1'b1;
      else if (uf_clr) underflow <= 1'b0;
    end
  end

  assign frame_start     = fs_q;
  assign state_dbg       = (state_q == RUN);
  assign video_ifm.clk   = pixel_clk;
  assign video_ifm.hs    = hs_q;
  assign video_ifm.vs    = vs_q;
  assign video_ifm.blank = blank_q;
  assign video_ifm.rgb   = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: random stimulus, a frame-position reference model,
// and a per-cycle scoreboard of the raster outputs and fifo_rd.
module tb_vga_timing_gen;

  localparam int HDISP = 36, VDISP = 8;
  localparam int HFP = 3, HPULSE = 4, HBP = 5;
  localparam int VFP = 2, VPULSE = 2, VBP = 3;
  localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
  localparam int GRID = 8;
  localparam logic [23:0] UF_RGB = 24'hFF00FF;

  localparam int HT    = HDISP + HFP + HPULSE + HBP;
  localparam int VT    = VDISP + VFP + VPULSE + VBP;
  localparam int FRAME = HT * VT;
  localparam int HS0   = HFP + HPULSE + HBP;
  localparam int VS0   = VFP + VPULSE + VBP;
  localparam int BARW  = HDISP / 8;
  localparam int W     = 29;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic [23:0] fifo_data = 24'h0;
  logic        fifo_empty = 1'b1;
  logic        underflow_clr = 1'b0;
  logic        fifo_rd, underflow, frame_start, state_dbg;

  video_if vif ();

  vga_timing_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(HS_POL), .VS_POL(VS_POL),
    .GRID_STEP(GRID), .UNDERFLOW_RGB(UF_RGB)
  ) dut (
    .pixel_clk     (pixel_clk),
    .pixel_rst     (pixel_rst),
    .enable        (enable),
    .mode          (mode),
    .solid_rgb     (solid_rgb),
    .fifo_data     (fifo_data),
    .fifo_empty    (fifo_empty),
    .fifo_rd       (fifo_rd),
    .underflow_clr (underflow_clr),
    .underflow     (underflow),
    .frame_start   (frame_start),
    .state_dbg     (state_dbg),
    .video_ifm     (vif)
  );

  // ---------------- clock ----------------
  always #5 pixel_clk = ~pixel_clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic         rd_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model state ----------------
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [23:0] m_solid = 24'h0;
  logic        m_uf = 1'b0;
  logic [23:0] bar_tbl [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // ---------------- FIFO source ----------------
  logic [23:0] fifo_q[$];
  logic [23:0] data_ctr = 24'h000100;
  bit          force_empty = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // One pixel clock of the reference: position in frame as a single index,
  // regions and patterns derived with plain arithmetic.
  task automatic model_step(output logic [W-1:0] e, output logic rd);
    int h, v, x, y, bi;
    logic hs_e, vs_e, act, fs, set;
    logic [23:0] c;
    rd = 1'b0; set = 1'b0; c = 24'h0; act = 1'b0; fs = 1'b0;
    hs_e = !HS_POL; vs_e = !VS_POL;
    if (pixel_rst) begin
      m_run = 1'b0; m_t = 0; m_uf = 1'b0; m_mode = 2'd0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1'b1; m_t = 0; m_mode = mode; m_solid = solid_rgb;
      end
    end else begin
      h = m_t % HT;
      v = m_t / HT;
      if (m_t == 0) begin
        m_mode = mode; m_solid = solid_rgb;
      end
      act  = (h >= HS0) && (v >= VS0);
      x    = h - HS0;
      y    = v - VS0;
      hs_e = (h >= HFP && h < HFP + HPULSE) ? HS_POL : !HS_POL;
      vs_e = (v >= VFP && v < VFP + VPULSE) ? VS_POL : !VS_POL;
      fs   = (m_t == 0);
      if (act) begin
        case (m_mode)
          2'd0: c = ((x % GRID == 0) || (y % GRID == 0)) ? 24'hFFFFFF : 24'h000000;
          2'd1: begin
            bi = x / BARW;
            if (bi > 7) bi = 7;
            c = bar_tbl[bi];
          end
          2'd2: begin
            if (fifo_empty) begin
              c = UF_RGB; set = 1'b1;
            end else begin
              c = fifo_data; rd = 1'b1;
            end
          end
          default: c = m_solid;
        endcase
      end
      if (set) m_uf = 1'b1;
      else if (underflow_clr) m_uf = 1'b0;
      m_t++;
      if (m_t == FRAME) begin
        m_t = 0;
        if (!enable) m_run = 1'b0;
      end
    end
    e = {hs_e, vs_e, act, fs, m_uf, c};
  endtask

  // ---------------- driver ----------------
  task automatic step();
    logic [W-1:0] e;
    logic rd;
    if (fifo_q.size() < 4 && $urandom_range(0, 15) != 0) begin
      fifo_q.push_back(data_ctr);
      data_ctr = data_ctr + 24'd1;
    end
    fifo_empty = force_empty || (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 24'($urandom) : fifo_q[0];
    model_step(e, rd);
    if (rd) void'(fifo_q.pop_front());
    exp_q.push_back(e);
    rd_q.push_back(rd);
    @(posedge pixel_clk);
    #2;
  endtask

  task automatic step_until(input int target);
    int n = 0;
    while (!(m_run && m_t == target) && n < 3 * FRAME) begin
      step();
      n++;
    end
    if (n >= 3 * FRAME) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_position: target %0d not reached, model t=%0d", target, m_t);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"},    vif.hs, !HS_POL);
    check({tag, "_vs"},    vif.vs, !VS_POL);
    check({tag, "_blank"}, vif.blank, 1'b0);
    check({tag, "_rgb"},   vif.rgb, 24'h0);
    check({tag, "_fs"},    frame_start, 1'b0);
    check({tag, "_rd"},    fifo_rd, 1'b0);
    check({tag, "_uf"},    underflow, 1'b0);
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  logic         mon_rd;
  initial begin : monitor
    forever begin
      @(posedge pixel_clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("hs/vs/blank/fs/uf/rgb",
              {3'b000, vif.hs, vif.vs, vif.blank, frame_start, underflow, vif.rgb}, {3'b000, mon_e});
      end
      @(negedge pixel_clk);
      if (rd_q.size() > 0) begin
        mon_rd = rd_q.pop_front();
        check("fifo_rd", fifo_rd, mon_rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    pixel_rst = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #2;
    check_reset_outputs("reset");
    pixel_rst = 1'b0;
    repeat (5) step();

    // grid pattern for a full frame
    enable = 1'b1; mode = 2'd0;
    repeat (FRAME + 10) step();

    // colour bars, then solid requested mid-frame
    mode = 2'd1;
    repeat (FRAME) step();
    step_until(4 * HT + 20);
    mode = 2'd3; solid_rgb = 24'($urandom);
    repeat (FRAME + 30) step();

    // streamed pixels with a forced 5-cycle underflow then a clear
    mode = 2'd2;
    repeat (FRAME) step();
    step_until((VS0 + 2) * HT + HS0 + 5);
    force_empty = 1'b1;
    repeat (5) step();
    force_empty = 1'b0;
    repeat (20) step();
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    repeat (FRAME) step();

    // enable dropped mid-frame: frame completes, then idle
    step_until(5 * HT + 7);
    enable = 1'b0;
    repeat (FRAME + 15) step();
    // enable dropped and re-raised within one frame: no gap
    enable = 1'b1; mode = 2'd1;
    step_until(6 * HT);
    enable = 1'b0;
    repeat (HT * 3) step();
    enable = 1'b1;
    repeat (FRAME) step();

    // reset in the middle of a frame
    step_until(3 * HT + 20);
    pixel_rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    step();
    step();
    pixel_rst = 1'b0;
    repeat (FRAME + 10) step();

    // randomized run
    for (int i = 0; i < 6 * FRAME; i++) begin
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) solid_rgb = 24'($urandom);
      underflow_clr = ($urandom_range(0, 99) == 0);
      force_empty   = ($urandom_range(0, 19) == 0);
      step();
    end
    underflow_clr = 1'b0;
    force_empty = 1'b0;

    // wind down to idle
    enable = 1'b0;
    repeat (FRAME + 20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
